// File: rtl/signed_div_seq.sv
// Multi-cycle signed divider: magnitude conversion, WIDTH-step restoring
// shift-subtract loop, then sign restoration; results handed off with a done pulse.
module signed_div_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             unsupported
);

   typedef enum logic [1:0] {IDLE, ABS, DIV, SIGN} state_t;

   localparam int               CW      = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mag_q, mag_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rmd_q, rmd_d;
   logic             dbz_q, dbz_d;
   logic             uns_q, uns_d;

   logic [WIDTH:0]   shift_s;
   logic [WIDTH:0]   diff_s;

   function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
      return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
   endfunction

   // acc_q starts as the dividend magnitude and fills with quotient bits as it shifts out
   assign shift_s = {rem_q, acc_q[WIDTH-1]};
   assign diff_s  = shift_s - {1'b0, mag_q};

   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      acc_d   = acc_q;
      mag_d   = mag_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      quo_d   = quo_q;
      rmd_d   = rmd_q;
      dbz_d   = dbz_q;
      uns_d   = uns_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               dvd_d   = dividend;
               dvs_d   = divisor;
               busy_d  = 1'b1;
               state_d = ABS;
            end else begin
               state_d = IDLE;
            end
         end
         ABS: begin
            if ((dvs_q == '0) || (dvd_q == MIN_INT) || (dvs_q == MIN_INT)) begin
               state_d = IDLE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               dbz_d   = (dvs_q == '0);
               uns_d   = (dvd_q == MIN_INT) || (dvs_q == MIN_INT);
               if (dvs_q == '0) begin
                  quo_d = '1;
                  rmd_d = dvd_q;
               end else begin
                  quo_d = '0;
                  rmd_d = '0;
               end
            end else begin
               acc_d   = abs_val(dvd_q);
               mag_d   = abs_val(dvs_q);
               rem_d   = '0;
               cnt_d   = '0;
               state_d = DIV;
            end
         end
         DIV: begin
            if (!diff_s[WIDTH]) begin
               rem_d = diff_s[WIDTH-1:0];
               acc_d = {acc_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = shift_s[WIDTH-1:0];
               acc_d = {acc_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = SIGN;
            end else begin
               state_d = DIV;
            end
         end
         SIGN: begin
            quo_d   = (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]) ? (~acc_q + WIDTH'(1)) : acc_q;
            rmd_d   = dvd_q[WIDTH-1] ? (~rem_q + WIDTH'(1)) : rem_q;
            dbz_d   = 1'b0;
            uns_d   = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         acc_q   <= '0;
         mag_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         quo_q   <= '0;
         rmd_q   <= '0;
         dbz_q   <= 1'b0;
         uns_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         acc_q   <= acc_d;
         mag_q   <= mag_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         quo_q   <= quo_d;
         rmd_q   <= rmd_d;
         dbz_q   <= dbz_d;
         uns_q   <= uns_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quo_q;
   assign remainder   = rmd_q;
   assign div_by_zero = dbz_q;
   assign unsupported = uns_q;

endmodule
